// File: rtl/simon_pkg.sv
// Shared types and constants for the Simon sequence engine.
//   color_t       : 2-bit button / lamp colour
//   state_t       : engine FSM states
//   DEPTH_DEFAULT : default maximum sequence length
package simon_pkg;

   typedef logic [1:0] color_t;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_RND = 2'd1,
      PLAY     = 2'd2,
      CHECK    = 2'd3
   } state_t;

   localparam int DEPTH_DEFAULT = 32;

endpackage

// File: rtl/simon_seq_mem.sv
// Sequence storage: DEPTH x 2-bit register file.
//   clk   : write clock
//   we    : write enable, waddr/wdata sampled on the rising edge
//   raddr : read address, rdata is combinational
// Contents are not reset; the engine never reads above level-1.
module simon_seq_mem
   import simon_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEFAULT,
   parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  color_t        wdata,
   input  logic [AW-1:0] raddr,
   output color_t        rdata
);

   color_t mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem_q[waddr] <= wdata;
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/simon_sequence_engine.sv
// Simon game sequence engine: appends random colours, plays the stored
// sequence back on pacing ticks, then checks the player's presses.
//   clk, rst_n              : clock, async active-low reset
//   rnd_ready, rnd_value    : random colour source
//   clear                   : synchronous wipe of the sequence
//   append_req, play_start  : IDLE-only commands
//   play_tick               : playback pacing strobe
//   check_valid/check_color : player button press
//   play_valid/play_color/play_done, round_ok, round_fail, full_err : results
//   level, busy             : stored entry count, FSM not IDLE
module simon_sequence_engine
   import simon_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEFAULT,
   parameter int LW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          rnd_ready,
   input  logic [1:0]    rnd_value,
   input  logic          clear,
   input  logic          append_req,
   input  logic          play_start,
   input  logic          play_tick,
   input  logic          check_valid,
   input  logic [1:0]    check_color,
   output logic          play_valid,
   output logic [1:0]    play_color,
   output logic          play_done,
   output logic          round_ok,
   output logic          round_fail,
   output logic          full_err,
   output logic [LW-1:0] level,
   output logic          busy
);

   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   state_t          state_q, state_d;
   logic [LW-1:0]   level_q, level_d;
   logic [IW-1:0]   idx_q, idx_d;
   color_t          play_color_q, play_color_d;
   logic            play_valid_q, play_valid_d;
   logic            play_done_q, play_done_d;
   logic            round_ok_q, round_ok_d;
   logic            round_fail_q, round_fail_d;
   logic            full_err_q, full_err_d;
   logic            busy_q, busy_d;

   logic            mem_we;
   color_t          rd_color;
   logic            last;

   simon_seq_mem #(.DEPTH(DEPTH), .AW(IW)) u_mem (
      .clk   (clk),
      .we    (mem_we),
      .waddr (IW'(level_q)),
      .wdata (rnd_value),
      .raddr (idx_q),
      .rdata (rd_color)
   );

   always_comb begin
      state_d      = state_q;
      level_d      = level_q;
      idx_d        = idx_q;
      play_color_d = play_color_q;
      play_valid_d = 1'b0;
      play_done_d  = 1'b0;
      round_ok_d   = 1'b0;
      round_fail_d = 1'b0;
      full_err_d   = 1'b0;
      mem_we       = 1'b0;
      // idx is addressing the final stored entry
      last         = (LW'(idx_q) == level_q - LW'(1));

      if (clear) begin
         state_d = IDLE;
         level_d = '0;
         idx_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               // append_req outranks play_start
               if (append_req) begin
                  if (level_q < LW'(DEPTH)) state_d = WAIT_RND;
                  else                      full_err_d = 1'b1;
               end else if (play_start && level_q != '0) begin
                  idx_d   = '0;
                  state_d = PLAY;
               end
            end
            WAIT_RND: begin
               if (rnd_ready) begin
                  mem_we  = 1'b1;
                  level_d = level_q + LW'(1);
                  state_d = IDLE;
               end
            end
            PLAY: begin
               if (play_tick) begin
                  play_valid_d = 1'b1;
                  play_color_d = rd_color;
                  if (last) begin
                     play_done_d = 1'b1;
                     idx_d       = '0;
                     state_d     = CHECK;
                  end else begin
                     idx_d = idx_q + IW'(1);
                  end
               end
            end
            CHECK: begin
               if (check_valid) begin
                  if (check_color == rd_color) begin
                     if (last) begin
                        round_ok_d = 1'b1;
                        idx_d      = '0;
                        state_d    = IDLE;
                     end else begin
                        idx_d = idx_q + IW'(1);
                     end
                  end else begin
                     round_fail_d = 1'b1;
                     idx_d        = '0;
                     state_d      = IDLE;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end

      // registered so busy tracks state_q exactly
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         level_q      <= '0;
         idx_q        <= '0;
         play_color_q <= '0;
         play_valid_q <= 1'b0;
         play_done_q  <= 1'b0;
         round_ok_q   <= 1'b0;
         round_fail_q <= 1'b0;
         full_err_q   <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         level_q      <= level_d;
         idx_q        <= idx_d;
         play_color_q <= play_color_d;
         play_valid_q <= play_valid_d;
         play_done_q  <= play_done_d;
         round_ok_q   <= round_ok_d;
         round_fail_q <= round_fail_d;
         full_err_q   <= full_err_d;
         busy_q       <= busy_d;
      end
   end

   assign play_valid = play_valid_q;
   assign play_color = play_color_q;
   assign play_done  = play_done_q;
   assign round_ok   = round_ok_q;
   assign round_fail = round_fail_q;
   assign full_err   = full_err_q;
   assign level      = level_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_simon_sequence_engine.sv
// Bench for simon_sequence_engine: a cycle table for the basic
// append/play/check flow plus hand-written corner sequences. Expected
// playback colours go into a queue when the tick is driven and are
// popped by a monitor whenever play_valid is seen.
module tb_simon_sequence_engine;

   localparam int DEPTH = 32;
   localparam int LW    = $clog2(DEPTH + 1);

   logic          clk = 1'b0;
   logic          rst_n;
   logic          rnd_ready, clear, append_req, play_start, play_tick, check_valid;
   logic [1:0]    rnd_value, check_color;
   logic          play_valid, play_done, round_ok, round_fail, full_err, busy;
   logic [1:0]    play_color;
   logic [LW-1:0] level;

   int n_pass  = 0;
   int n_total = 0;
   logic [1:0] exp_q [$];

   simon_sequence_engine #(.DEPTH(DEPTH), .LW(LW)) dut (
      .clk(clk), .rst_n(rst_n), .rnd_ready(rnd_ready), .rnd_value(rnd_value),
      .clear(clear), .append_req(append_req), .play_start(play_start),
      .play_tick(play_tick), .check_valid(check_valid), .check_color(check_color),
      .play_valid(play_valid), .play_color(play_color), .play_done(play_done),
      .round_ok(round_ok), .round_fail(round_fail), .full_err(full_err),
      .level(level), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   // scoreboard consumer
   always @(negedge clk) begin
      if (rst_n && play_valid) begin
         if (exp_q.size() == 0) chk("unexpected_play_valid", 1, 0);
         else chk("sb_play_color", int'(play_color), int'(exp_q.pop_front()));
      end
   end

   task automatic idle_in();
      rnd_ready = 0; rnd_value = 0; clear = 0; append_req = 0;
      play_start = 0; play_tick = 0; check_valid = 0; check_color = 0;
   endtask

   task automatic cyc();
      @(posedge clk); #1;
   endtask

   task automatic append(input logic [1:0] c);
      idle_in(); append_req = 1; cyc();
      idle_in(); rnd_ready = 1; rnd_value = c; cyc();
      idle_in();
   endtask

   typedef struct {
      logic ap, rr; logic [1:0] rv; logic ps, pt, cv; logic [1:0] cc;
      logic e_pv; logic [1:0] e_pc; logic e_pd, e_ok, e_fail; int e_lvl; logic e_busy;
   } vec_t;

   vec_t tbl [25];

   function automatic vec_t mk(logic ap, logic rr, logic [1:0] rv, logic ps, logic pt,
                               logic cv, logic [1:0] cc, logic pv, logic [1:0] pc,
                               logic pd, logic ok, logic fl, int lvl, logic bsy);
      vec_t v;
      v.ap = ap; v.rr = rr; v.rv = rv; v.ps = ps; v.pt = pt; v.cv = cv; v.cc = cc;
      v.e_pv = pv; v.e_pc = pc; v.e_pd = pd; v.e_ok = ok; v.e_fail = fl;
      v.e_lvl = lvl; v.e_busy = bsy;
      return v;
   endfunction

   logic [1:0] big_seq [DEPTH];

   initial begin
      //              ap rr rv ps pt cv cc   pv pc pd ok fl lvl busy
      tbl[0]  = mk(1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1);
      tbl[1]  = mk(0, 1, 2, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1, 0);
      tbl[2]  = mk(1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1, 1);
      tbl[3]  = mk(0, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 2, 0);
      tbl[4]  = mk(1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 2, 1);
      tbl[5]  = mk(0, 0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 2, 1);
      tbl[6]  = mk(0, 1, 3, 0, 0, 0, 0,  0, 0, 0, 0, 0, 3, 0);
      tbl[7]  = mk(0, 0, 0, 1, 0, 0, 0,  0, 0, 0, 0, 0, 3, 1);
      tbl[8]  = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 3, 1);
      tbl[9]  = mk(0, 0, 0, 0, 1, 0, 0,  1, 2, 0, 0, 0, 3, 1);
      tbl[10] = mk(0, 0, 0, 0, 0, 0, 0,  0, 2, 0, 0, 0, 3, 1);
      tbl[11] = mk(0, 0, 0, 0, 1, 0, 0,  1, 0, 0, 0, 0, 3, 1);
      tbl[12] = mk(0, 0, 0, 0, 1, 0, 0,  1, 3, 1, 0, 0, 3, 1);
      tbl[13] = mk(0, 0, 0, 0, 0, 1, 2,  0, 3, 0, 0, 0, 3, 1);
      tbl[14] = mk(0, 0, 0, 0, 0, 0, 0,  0, 3, 0, 0, 0, 3, 1);
      tbl[15] = mk(0, 0, 0, 0, 0, 1, 0,  0, 3, 0, 0, 0, 3, 1);
      tbl[16] = mk(0, 0, 0, 0, 0, 1, 3,  0, 3, 0, 1, 0, 3, 0);
      tbl[17] = mk(0, 0, 0, 0, 1, 1, 1,  0, 3, 0, 0, 0, 3, 0);
      tbl[18] = mk(0, 0, 0, 1, 0, 0, 0,  0, 3, 0, 0, 0, 3, 1);
      tbl[19] = mk(0, 0, 0, 0, 1, 0, 0,  1, 2, 0, 0, 0, 3, 1);
      tbl[20] = mk(0, 0, 0, 0, 1, 0, 0,  1, 0, 0, 0, 0, 3, 1);
      tbl[21] = mk(0, 0, 0, 0, 1, 0, 0,  1, 3, 1, 0, 0, 3, 1);
      tbl[22] = mk(0, 0, 0, 0, 0, 1, 2,  0, 3, 0, 0, 0, 3, 1);
      tbl[23] = mk(0, 0, 0, 0, 0, 1, 1,  0, 3, 0, 0, 1, 3, 0);
      tbl[24] = mk(0, 0, 0, 0, 0, 0, 0,  0, 3, 0, 0, 0, 3, 0);

      // reset state
      idle_in(); rst_n = 0;
      cyc(); cyc();
      chk("rst_play_valid", play_valid, 0);
      chk("rst_play_color", play_color, 0);
      chk("rst_level", level, 0);
      chk("rst_busy", busy, 0);
      chk("rst_pulses", {play_done, round_ok, round_fail, full_err}, 0);
      rst_n = 1;
      cyc();

      // scenarios 1 and 2 from the table
      for (int i = 0; i < 25; i++) begin
         idle_in();
         append_req = tbl[i].ap; rnd_ready = tbl[i].rr; rnd_value = tbl[i].rv;
         play_start = tbl[i].ps; play_tick = tbl[i].pt;
         check_valid = tbl[i].cv; check_color = tbl[i].cc;
         if (tbl[i].e_pv) exp_q.push_back(tbl[i].e_pc);
         cyc();
         chk($sformatf("v%0d_play_valid", i), play_valid, tbl[i].e_pv);
         chk($sformatf("v%0d_play_color", i), play_color, tbl[i].e_pc);
         chk($sformatf("v%0d_play_done", i), play_done, tbl[i].e_pd);
         chk($sformatf("v%0d_round_ok", i), round_ok, tbl[i].e_ok);
         chk($sformatf("v%0d_round_fail", i), round_fail, tbl[i].e_fail);
         chk($sformatf("v%0d_level", i), level, tbl[i].e_lvl);
         chk($sformatf("v%0d_busy", i), busy, tbl[i].e_busy);
      end
      idle_in();

      // scenario 3: fill to DEPTH, refuse one more, replay and check all
      clear = 1; cyc(); idle_in();
      chk("clr_level", level, 0);
      chk("clr_busy", busy, 0);
      for (int i = 0; i < DEPTH; i++) begin
         big_seq[i] = 2'((i * 3 + 1) % 4);
         append(big_seq[i]);
      end
      chk("full_level", level, DEPTH);
      append_req = 1; cyc(); idle_in();
      chk("full_err_pulse", full_err, 1);
      chk("full_err_busy", busy, 0);
      cyc();
      chk("full_err_once", full_err, 0);
      chk("full_level_kept", level, DEPTH);
      play_start = 1; cyc(); idle_in();
      for (int i = 0; i < DEPTH; i++) begin
         play_tick = 1; exp_q.push_back(big_seq[i]); cyc(); idle_in();
         chk("full_play_done", play_done, (i == DEPTH - 1) ? 1 : 0);
      end
      for (int i = 0; i < DEPTH; i++) begin
         check_valid = 1; check_color = big_seq[i]; cyc(); idle_in();
         chk("full_round_ok", round_ok, (i == DEPTH - 1) ? 1 : 0);
      end
      chk("full_idle", busy, 0);

      // scenario 4: play_start on empty; append beats play_start
      clear = 1; cyc(); idle_in();
      play_start = 1; cyc(); idle_in();
      chk("empty_play_busy", busy, 0);
      play_tick = 1; cyc(); idle_in();
      chk("empty_tick_busy", busy, 0);
      append(2'd1);
      append_req = 1; play_start = 1; cyc(); idle_in();
      chk("append_wins_busy", busy, 1);
      play_tick = 1; cyc(); idle_in();   // in WAIT_RND: must not play
      chk("wait_rnd_holds", busy, 1);
      rnd_ready = 1; rnd_value = 2; cyc(); idle_in();
      chk("append_wins_level", level, 2);
      chk("append_wins_idle", busy, 0);

      // scenario 5: clear during CHECK at idx=1
      play_start = 1; cyc(); idle_in();
      play_tick = 1; exp_q.push_back(2'd1); cyc();
      exp_q.push_back(2'd2); cyc(); idle_in();
      chk("s5_play_done", play_done, 1);
      check_valid = 1; check_color = 1; cyc(); idle_in();
      clear = 1; check_valid = 1; check_color = 2; cyc(); idle_in();
      chk("s5_busy", busy, 0);
      chk("s5_level", level, 0);
      chk("s5_no_result", {round_ok, round_fail}, 0);
      cyc();
      chk("s5_no_result_late", {round_ok, round_fail}, 0);

      // scenario 6: async reset mid-PLAY
      append(2'd3); append(2'd1);
      play_start = 1; cyc(); idle_in();
      play_tick = 1; exp_q.push_back(2'd3); cyc(); idle_in();
      @(negedge clk); #1;
      rst_n = 0; #1;
      chk("s6_rst_level", level, 0);
      chk("s6_rst_busy", busy, 0);
      chk("s6_rst_color", play_color, 0);
      chk("s6_rst_pulses", {play_valid, play_done, round_ok, round_fail, full_err}, 0);
      chk("s6_sb_empty", exp_q.size(), 0);
      exp_q.delete();
      cyc(); rst_n = 1;
      play_start = 1; cyc(); idle_in();
      chk("s6_start_ignored", busy, 0);
      play_tick = 1; cyc(); idle_in();
      chk("s6_still_idle", busy, 0);

      @(negedge clk); #1;
      chk("sb_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
